// File: rtl/sdram_ctrl.sv
// Closed-page SDR SDRAM controller: power-up init, auto-refresh and
// single-word ACTIVATE -> READ/WRITE -> PRECHARGE accesses.
module sdram_ctrl #(
  parameter int CAS_LATENCY      = 2,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int T_RC             = 7,
  parameter int T_MRD            = 2,
  parameter int T_WR             = 2,
  parameter int INIT_WAIT        = 10000,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        init_done,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_a,
  output logic [15:0] sdram_dq_o,
  output logic        sdram_dq_oe,
  input  logic [15:0] sdram_dq_i,
  output logic [1:0]  sdram_dm
);

  // Floor of 64 keeps the timing loads representable with a tiny INIT_WAIT.
  localparam int CW = $clog2((INIT_WAIT > 64 ? INIT_WAIT : 64) + 1);
  localparam int RW = $clog2(REFRESH_INTERVAL + 1);

  localparam logic [CW-1:0] LD_RP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] LD_RC  = CW'(T_RC - 1);
  localparam logic [CW-1:0] LD_MRD = CW'(T_MRD - 1);
  localparam logic [CW-1:0] LD_RCD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] LD_WR  = CW'(T_WR - 1);
  localparam logic [CW-1:0] LD_CL  = CW'(CAS_LATENCY);
  localparam logic [RW-1:0] LD_REF = RW'(REFRESH_INTERVAL - 1);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam logic [12:0] MODE =
    {3'b000, 1'b1, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b000};

  typedef enum logic [3:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2,
    S_INIT_MRS, S_IDLE, S_ACTIVATE, S_RCD_WAIT,
    S_READ, S_CAS_WAIT, S_WRITE, S_WR_RECOVER,
    S_PRECHARGE, S_RP_WAIT, S_REFRESH, S_RC_WAIT
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt, w_dec;
  logic          w_zero;
  logic [RW-1:0] r_ref_cnt;
  logic          r_ref_pend;
  logic          r_init_done;
  logic [23:0]   r_addr;
  logic          r_we;
  logic [15:0]   r_wdata;
  logic [1:0]    r_be;
  logic          r_rsp_valid;
  logic [15:0]   r_rsp_rdata;
  logic          r_cke;
  logic [3:0]    r_cmd, w_cmd;
  logic [1:0]    r_ba, w_ba;
  logic [12:0]   r_a, w_a;
  logic [15:0]   r_dq_o, w_dq_o;
  logic          r_dq_oe, w_dq_oe;
  logic [1:0]    r_dm, w_dm;
  logic          w_accept, w_ref_go, w_init_fin, w_sample;

  assign w_zero    = (r_cnt == '0);
  assign w_dec     = r_cnt - CW'(1);
  assign req_ready = (r_state == S_IDLE) && r_init_done && !r_ref_pend;

  always_comb begin
    w_state    = r_state;
    w_cnt      = w_zero ? r_cnt : w_dec;
    w_cmd      = CMD_NOP;
    w_ba       = r_ba;
    w_a        = r_a;
    w_dq_o     = r_dq_o;
    w_dq_oe    = 1'b0;
    w_dm       = 2'b11;
    w_accept   = 1'b0;
    w_ref_go   = 1'b0;
    w_init_fin = 1'b0;
    w_sample   = 1'b0;
    unique case (r_state)
      S_INIT_WAIT: if (w_zero) begin
        w_state = S_INIT_PRE;
        w_cmd   = CMD_PRE;
        w_ba    = 2'd0;
        w_a     = 13'h0400;
        w_cnt   = LD_RP;
      end
      S_INIT_PRE: if (w_zero) begin
        w_state = S_INIT_REF1;
        w_cmd   = CMD_REF;
        w_cnt   = LD_RC;
      end
      S_INIT_REF1: if (w_zero) begin
        w_state = S_INIT_REF2;
        w_cmd   = CMD_REF;
        w_cnt   = LD_RC;
      end
      S_INIT_REF2: if (w_zero) begin
        w_state = S_INIT_MRS;
        w_cmd   = CMD_MRS;
        w_ba    = 2'd0;
        w_a     = MODE;
        w_cnt   = LD_MRD;
      end
      S_INIT_MRS: if (w_zero) begin
        w_state    = S_IDLE;
        w_init_fin = 1'b1;
      end
      S_IDLE: begin
        if (r_ref_pend) begin
          w_state  = S_REFRESH;
          w_cmd    = CMD_REF;
          w_cnt    = LD_RC;
          w_ref_go = 1'b1;
        end else if (req_valid && req_ready) begin
          w_state  = S_ACTIVATE;
          w_cmd    = CMD_ACT;
          w_ba     = req_addr[23:22];
          w_a      = req_addr[21:9];
          w_cnt    = LD_RCD;
          w_accept = 1'b1;
        end
      end
      S_ACTIVATE, S_RCD_WAIT: begin
        if (!w_zero) begin
          w_state = S_RCD_WAIT;
        end else if (r_we) begin
          w_state = S_WRITE;
          w_cmd   = CMD_WR;
          w_a     = {4'b0000, r_addr[8:0]};
          w_dq_oe = 1'b1;
          w_dq_o  = r_wdata;
          w_dm    = ~r_be;
          w_cnt   = LD_WR;
        end else begin
          w_state = S_READ;
          w_cmd   = CMD_RD;
          w_a     = {4'b0000, r_addr[8:0]};
          w_dm    = 2'b00;
          w_cnt   = LD_CL;
        end
      end
      S_WRITE, S_WR_RECOVER, S_READ, S_CAS_WAIT: begin
        if (!w_zero) begin
          w_state = r_we ? S_WR_RECOVER : S_CAS_WAIT;
        end else begin
          w_state  = S_PRECHARGE;
          w_cmd    = CMD_PRE;
          w_a      = 13'h0000;
          w_cnt    = LD_RP;
          w_sample = !r_we;
        end
      end
      S_PRECHARGE, S_RP_WAIT:
        w_state = w_zero ? S_IDLE : S_RP_WAIT;
      S_REFRESH, S_RC_WAIT:
        w_state = w_zero ? S_IDLE : S_RC_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT_WAIT;
      r_cnt   <= CW'(INIT_WAIT);
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cke       <= 1'b0;
      r_cmd       <= 4'b1111;
      r_ba        <= 2'd0;
      r_a         <= 13'h0000;
      r_dq_o      <= 16'h0000;
      r_dq_oe     <= 1'b0;
      r_dm        <= 2'b11;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'h0000;
      r_init_done <= 1'b0;
    end else begin
      r_cke       <= 1'b1;
      r_cmd       <= w_cmd;
      r_ba        <= w_ba;
      r_a         <= w_a;
      r_dq_o      <= w_dq_o;
      r_dq_oe     <= w_dq_oe;
      r_dm        <= w_dm;
      r_rsp_valid <= w_sample;
      if (w_sample) r_rsp_rdata <= sdram_dq_i;
      if (w_init_fin) r_init_done <= 1'b1;
    end
  end

  // An expiry that lands while a refresh is already owed is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else begin
      if (w_init_fin)
        r_ref_cnt <= LD_REF;
      else if (r_init_done)
        r_ref_cnt <= (r_ref_cnt == '0) ? LD_REF : r_ref_cnt - RW'(1);
      if (w_ref_go)
        r_ref_pend <= 1'b0;
      else if (r_init_done && r_ref_cnt == '0)
        r_ref_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= req_addr;
      r_we    <= req_we;
      r_wdata <= req_wdata;
      r_be    <= req_be;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign init_done   = r_init_done;
  assign sdram_cke   = r_cke;
  assign sdram_cs_n  = r_cmd[3];
  assign sdram_ras_n = r_cmd[2];
  assign sdram_cas_n = r_cmd[1];
  assign sdram_we_n  = r_cmd[0];
  assign sdram_ba    = r_ba;
  assign sdram_a     = r_a;
  assign sdram_dq_o  = r_dq_o;
  assign sdram_dq_oe = r_dq_oe;
  assign sdram_dm    = r_dm;

endmodule
